// File: rtl/mem_block_arbiter.sv
// Arbiter for the shared block-transfer memory port (I-cache reads vs data-side reads/write-backs).
// Define ARB_ROUND_ROBIN_EN to alternate winners on ties; otherwise the data side has fixed priority.
module mem_block_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic [BLK_W-1:0]  i_data,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic [BLK_W-1:0]  d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_blk_read,
  output logic              mem_blk_write,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_read_valid,
  input  logic              mem_write_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, I_READ, D_READ, D_WRITE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLK_W-1:0]   wdata_q, wdata_d;
  logic               grant_i, grant_d;
  logic               tie_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_i_q, last_i_d;

  // On a tie, I wins unless it won the previous grant.
  assign tie_i = ~last_i_q;

  always_comb begin
    last_i_d = last_i_q;
    if (grant_i)      last_i_d = 1'b1;
    else if (grant_d) last_i_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) last_i_q <= 1'b0;
    else       last_i_q <= last_i_d;
  end
`else
  assign tie_i = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    i_valid = 1'b0;
    d_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          grant_i = tie_i;
          grant_d = ~tie_i;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i) begin
          state_d = I_READ;
          addr_d  = i_address;
        end else if (grant_d) begin
          state_d = d_write ? D_WRITE : D_READ;
          addr_d  = d_address;
          if (d_write) wdata_d = d_wdata;
        end
      end
      I_READ: if (mem_read_valid) begin
        i_valid = 1'b1;
        state_d = IDLE;
      end
      D_READ: if (mem_read_valid) begin
        d_valid = 1'b1;
        state_d = IDLE;
      end
      D_WRITE: if (mem_write_valid) begin
        d_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes come from registered state only, so they never glitch on request inputs.
  assign mem_blk_read  = (state_q == I_READ) || (state_q == D_READ);
  assign mem_blk_write = (state_q == D_WRITE);
  assign busy          = (state_q != IDLE);
  assign mem_address   = addr_q;
  assign mem_wdata     = wdata_q;
  assign i_data        = mem_rdata;
  assign d_rdata       = mem_rdata;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Scoreboard bench for mem_block_arbiter: expected owner/data queued at grant, checked at completion.
module tb_mem_block_arbiter;
  localparam int ADDR_W = 32;
  localparam int BLK_W  = 256;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_req, d_req, d_write;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [BLK_W-1:0]  d_wdata, mem_rdata;
  logic              mem_read_valid, mem_write_valid;
  logic [BLK_W-1:0]  i_data, d_rdata, mem_wdata;
  logic              i_valid, d_valid, mem_blk_read, mem_blk_write, busy;
  logic [ADDR_W-1:0] mem_address;

  typedef struct {
    bit              is_i;
    logic [BLK_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_last_i = 1'b0;

  localparam logic [BLK_W-1:0] PAT_A = {8{32'hA5A5_0001}};
  localparam logic [BLK_W-1:0] PAT_B = {8{32'h5A5A_0B0B}};
  localparam logic [BLK_W-1:0] PAT_C = {8{32'hDEAD_BEEF}};
  localparam logic [ADDR_W-1:0] IA = 32'h0040_0020;
  localparam logic [ADDR_W-1:0] DA = 32'h1000_0040;

  always #5 CLK = ~CLK;

  mem_block_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_address(i_address), .i_data(i_data), .i_valid(i_valid),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_address(mem_address), .mem_blk_read(mem_blk_read), .mem_blk_write(mem_blk_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
    .busy(busy)
  );

  task automatic apply_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    m_last_i = 1'b0;
  endtask

  task automatic wait_strobe(output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      cyc++;
      if (mem_blk_read || mem_blk_write) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_strobe: no strobe within 20 cycles (busy=%0b)", busy);
    end
  endtask

  // Called at a negedge with the strobe up; pulses the memory valid after `delay` cycles.
  task automatic serve(input int delay, input bit wr, input logic [BLK_W-1:0] pat);
    exp_t e;
    repeat (delay) @(negedge CLK);
    mem_rdata = pat;
    if (wr) mem_write_valid = 1'b1;
    else    mem_read_valid  = 1'b1;
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL serve_sb: completion with empty scoreboard i_valid=%0b d_valid=%0b", i_valid, d_valid);
    end else begin
      e = sb.pop_front();
      if (i_valid !== e.is_i || d_valid !== !e.is_i) begin
        errors++;
        $display("FAIL serve_owner: i_valid=%0b d_valid=%0b, required i_valid=%0b d_valid=%0b",
                 i_valid, d_valid, e.is_i, !e.is_i);
      end else if (e.is_i && i_data !== e.data) begin
        errors++;
        $display("FAIL serve_i_data: got %h required %h", i_data, e.data);
      end else if (!e.is_i && !wr && d_rdata !== e.data) begin
        errors++;
        $display("FAIL serve_d_rdata: got %h required %h", d_rdata, e.data);
      end else if (!e.is_i && wr && mem_wdata !== e.data) begin
        errors++;
        $display("FAIL serve_wdata: got %h required %h", mem_wdata, e.data);
      end
    end
    @(posedge CLK); #1;
    mem_read_valid  = 1'b0;
    mem_write_valid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({busy, mem_blk_read, mem_blk_write, i_valid, d_valid} !== 5'b0 ||
        mem_address !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset: busy=%0b rd=%0b wr=%0b iv=%0b dv=%0b addr=%h wdata_nz=%0b, required all 0",
               busy, mem_blk_read, mem_blk_write, i_valid, d_valid, mem_address, |mem_wdata);
    end
    @(posedge CLK); #1 RESET = 1'b0;
    m_last_i = 1'b0;
  endtask

  task automatic test_i_only();
    @(posedge CLK); #1;
    i_req = 1'b1; i_address = IA;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (mem_blk_read !== 1'b1 || mem_blk_write !== 1'b0 || mem_address !== IA) begin
      errors++;
      $display("FAIL i_only_grant: rd=%0b wr=%0b addr=%h, required rd=1 wr=0 addr=%h",
               mem_blk_read, mem_blk_write, mem_address, IA);
    end
    sb.push_back('{is_i: 1'b1, data: PAT_A});
    m_last_i = 1'b1;
    serve(3, 1'b0, PAT_A);
    i_req = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || i_valid !== 1'b0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL i_only_after: busy=%0b iv=%0b dv=%0b, required 0 0 0", busy, i_valid, d_valid);
    end
  endtask

  task automatic test_d_write();
    @(posedge CLK); #1;
    d_req = 1'b1; d_write = 1'b1; d_address = DA; d_wdata = PAT_B;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (mem_blk_write !== 1'b1 || mem_blk_read !== 1'b0 || mem_wdata !== PAT_B || mem_address !== DA) begin
      errors++;
      $display("FAIL d_write_grant: wr=%0b rd=%0b addr=%h wdata=%h", mem_blk_write, mem_blk_read,
               mem_address, mem_wdata);
    end
    // A read completion during a write must be ignored.
    mem_rdata = PAT_C; mem_read_valid = 1'b1;
    #1;
    checks++;
    if (i_valid !== 1'b0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL d_write_ignore_rv: iv=%0b dv=%0b, required 0 0", i_valid, d_valid);
    end
    @(posedge CLK); #1 mem_read_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1 || mem_blk_write !== 1'b1) begin
      errors++;
      $display("FAIL d_write_still: busy=%0b wr=%0b, required 1 1", busy, mem_blk_write);
    end
    sb.push_back('{is_i: 1'b0, data: PAT_B});
    m_last_i = 1'b0;
    serve(1, 1'b1, PAT_C);
    d_req = 1'b0; d_write = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || mem_blk_write !== 1'b0) begin
      errors++;
      $display("FAIL d_write_after: busy=%0b wr=%0b, required 0 0", busy, mem_blk_write);
    end
  endtask

  task automatic test_tie();
    int  cyc;
    bit  exp_i;
    logic [BLK_W-1:0] pat;
    apply_reset();
    i_req = 1'b1; i_address = IA;
    d_req = 1'b1; d_write = 1'b0; d_address = DA;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_i = ~m_last_i;
`else
      exp_i = 1'b0;
`endif
      pat = PAT_A ^ BLK_W'(t * 32'h1111_0000 + 32'h77);
      wait_strobe(cyc);
      checks++;
      if (mem_blk_read !== 1'b1 || mem_address !== (exp_i ? IA : DA)) begin
        errors++;
        $display("FAIL tie_grant[%0d]: rd=%0b addr=%h, required rd=1 addr=%h", t, mem_blk_read,
                 mem_address, exp_i ? IA : DA);
      end
      sb.push_back('{is_i: exp_i, data: pat});
      m_last_i = exp_i;
      serve(1, 1'b0, pat);
    end
    d_req = 1'b0;
    wait_strobe(cyc);
    checks++;
    if (mem_address !== IA) begin
      errors++;
      $display("FAIL tie_i_after_d_low: addr=%h required %h", mem_address, IA);
    end
    sb.push_back('{is_i: 1'b1, data: PAT_C});
    m_last_i = 1'b1;
    serve(0, 1'b0, PAT_C);
    i_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    i_req = 1'b1; i_address = IA;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (mem_blk_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_grant: rd=%0b required 1", mem_blk_read);
    end
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0; i_req = 1'b0;
    m_last_i = 1'b0;
    @(negedge CLK);
    checks++;
    if (mem_blk_read !== 1'b0 || mem_blk_write !== 1'b0 || busy !== 1'b0 || i_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: rd=%0b wr=%0b busy=%0b iv=%0b, required 0", mem_blk_read,
               mem_blk_write, busy, i_valid);
    end
    mem_rdata = PAT_C; mem_read_valid = 1'b1; mem_write_valid = 1'b1;
    #1;
    checks++;
    if (i_valid !== 1'b0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_late_valid: iv=%0b dv=%0b, required 0 0", i_valid, d_valid);
    end
    @(posedge CLK); #1 mem_read_valid = 1'b0; mem_write_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(posedge CLK); #1;
    d_req = 1'b1; d_write = 1'b0; d_address = DA;
    wait_strobe(cyc);
    #1 i_req = 1'b1; i_address = IA;
    sb.push_back('{is_i: 1'b0, data: PAT_B});
    m_last_i = 1'b0;
    serve(2, 1'b0, PAT_B);
    d_req = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || mem_blk_read !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: busy=%0b rd=%0b in M+1, required 0 0", busy, mem_blk_read);
    end
    @(negedge CLK);
    checks++;
    if (mem_blk_read !== 1'b1 || mem_address !== IA) begin
      errors++;
      $display("FAIL b2b_next: rd=%0b addr=%h in M+2, required 1 %h", mem_blk_read, mem_address, IA);
    end
    sb.push_back('{is_i: 1'b1, data: PAT_A});
    m_last_i = 1'b1;
    serve(0, 1'b0, PAT_A);
    i_req = 1'b0;
    @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
  endtask

  initial begin
    RESET = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    mem_rdata = '0; mem_read_valid = 1'b0; mem_write_valid = 1'b0;
    test_reset();
    test_i_only();
    test_d_write();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
